// File: rtl/frame_parity_unit_if.sv
// Word-in / result-out bundle of the streaming frame parity unit.
// master = upstream word source and downstream result sink; slave = the parity unit.
interface frame_parity_unit_if #(
    parameter int DATA_W    = 8,
    parameter int MAX_WORDS = 16
);
    localparam int LEN_W = $clog2(MAX_WORDS + 1);

    // Both channels are valid/ready: a beat moves on a rising edge where valid and
    // ready are both high; valid and its payload stay put until that edge.
    logic              odd_mode;
    logic              chk_mode;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              in_last;
    logic              in_par;
    logic              out_valid;
    logic              out_ready;
    logic              out_par;
    logic              out_err;
    logic [LEN_W-1:0]  out_len;
    logic              out_ovf;

    modport master (
        output odd_mode, chk_mode, in_valid, in_data, in_last, in_par, out_ready,
        input  in_ready, out_valid, out_par, out_err, out_len, out_ovf
    );

    modport slave (
        input  odd_mode, chk_mode, in_valid, in_data, in_last, in_par, out_ready,
        output in_ready, out_valid, out_par, out_err, out_len, out_ovf
    );
endinterface

// File: rtl/frame_parity_unit.sv
// Streaming even/odd parity generator/checker over multi-word frames.
// One result per frame, held in registers until the downstream takes it.
module frame_parity_unit #(
    parameter int DATA_W    = 8,
    parameter int MAX_WORDS = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    frame_parity_unit_if.slave    bus,
    output logic [1:0]            dbg_state
);
    localparam int LEN_W = $clog2(MAX_WORDS + 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ACCUM = 2'd1,
        S_HOLD  = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic               acc_q, acc_d;
    logic [LEN_W-1:0]   cnt_q, cnt_d;
    logic               odd_q, odd_d;
    logic               chk_q, chk_d;
    logic               out_valid_q, out_valid_d;
    logic               out_par_q, out_par_d;
    logic               out_err_q, out_err_d;
    logic [LEN_W-1:0]   out_len_q, out_len_d;
    logic               out_ovf_q, out_ovf_d;

    logic               in_ready;
    logic               first_word;
    logic               word_fire;
    logic               odd_eff;
    logic               chk_eff;
    logic               acc_n;
    logic [LEN_W-1:0]   cnt_n;
    logic               closing;
    logic               par_n;

    assign in_ready = (state_q != S_HOLD);

    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        odd_d       = odd_q;
        chk_d       = chk_q;
        out_valid_d = out_valid_q;
        out_par_d   = out_par_q;
        out_err_d   = out_err_q;
        out_len_d   = out_len_q;
        out_ovf_d   = out_ovf_q;

        // The first word of a frame supplies the modes and restarts the running sums.
        first_word = (state_q == S_IDLE);
        word_fire  = bus.in_valid & in_ready;
        odd_eff    = first_word ? bus.odd_mode : odd_q;
        chk_eff    = first_word ? bus.chk_mode : chk_q;
        acc_n      = (first_word ? 1'b0 : acc_q) ^ (^bus.in_data);
        cnt_n      = (first_word ? '0 : cnt_q) + LEN_W'(1);
        closing    = bus.in_last | (cnt_n == LEN_W'(MAX_WORDS));
        par_n      = acc_n ^ odd_eff;

        case (state_q)
            S_IDLE, S_ACCUM: begin
                if (word_fire) begin
                    acc_d = acc_n;
                    cnt_d = cnt_n;
                    odd_d = odd_eff;
                    chk_d = chk_eff;
                    if (closing) begin
                        state_d     = S_HOLD;
                        out_valid_d = 1'b1;
                        out_par_d   = par_n;
                        out_ovf_d   = ~bus.in_last;
                        // A force-closed frame has no closing parity bit to compare against.
                        out_err_d   = chk_eff & bus.in_last & (par_n != bus.in_par);
                        out_len_d   = cnt_n;
                    end else begin
                        state_d = S_ACCUM;
                    end
                end
            end
            S_HOLD: begin
                if (bus.out_ready) begin
                    state_d     = S_IDLE;
                    out_valid_d = 1'b0;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            acc_q       <= 1'b0;
            cnt_q       <= '0;
            odd_q       <= 1'b0;
            chk_q       <= 1'b0;
            out_valid_q <= 1'b0;
            out_par_q   <= 1'b0;
            out_err_q   <= 1'b0;
            out_len_q   <= '0;
            out_ovf_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            odd_q       <= odd_d;
            chk_q       <= chk_d;
            out_valid_q <= out_valid_d;
            out_par_q   <= out_par_d;
            out_err_q   <= out_err_d;
            out_len_q   <= out_len_d;
            out_ovf_q   <= out_ovf_d;
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid_q;
    assign bus.out_par   = out_par_q;
    assign bus.out_err   = out_err_q;
    assign bus.out_len   = out_len_q;
    assign bus.out_ovf   = out_ovf_q;
    assign dbg_state     = state_q;
endmodule
